// File: rtl/updown_counter_param_if.sv
// Bus bundle for updown_counter_param: controls and load data in, count and flags out.
interface updown_counter_param_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             direction;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear_flags;
  logic [WIDTH-1:0] q;
  logic             carry;
  logic             borrow;
  logic             event_sticky;

  modport master (
    output enable, direction, load, load_value, clear_flags,
    input  q, carry, borrow, event_sticky
  );

  modport slave (
    input  enable, direction, load, load_value, clear_flags,
    output q, carry, borrow, event_sticky
  );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate, parallel load, carry/borrow pulses and sticky flag.
// Optional enable prescaler compiled in with `define COUNTER_PRESCALE_EN.
module updown_counter_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  updown_counter_param_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MAX_VAL);
  localparam bit               FULL_RANGE = (MAX_VAL == ((2**WIDTH) - 1));

  // Elaboration-time parameter sanity checks
  if (WIDTH < 2) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be >= 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("updown_counter_param: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             sticky_q, sticky_d;
  logic             step_c;
  logic             oor_c;
  logic [WIDTH-1:0] load_clamped_c;

  // A full-range counter can never be out of range or need a clamp
  if (FULL_RANGE) begin : g_full
    assign oor_c          = 1'b0;
    assign load_clamped_c = bus.load_value;
  end else begin : g_part
    assign oor_c          = (q_q > MAX_Q);
    assign load_clamped_c = (bus.load_value > MAX_Q) ? MAX_Q : bus.load_value;
  end

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTOP = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_c;

  assign tick_c = (presc_q == PTOP);
  assign step_c = bus.enable & ~bus.load & tick_c;

  // Prescaler advances on enabled cycles only; load restarts the period
  always_comb begin
    presc_d = presc_q;
    if (bus.load) begin
      presc_d = '0;
    end else if (bus.enable) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign step_c = bus.enable & ~bus.load;
`endif

  // Next count and limit pulses; range checks use the pre-step value
  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    sticky_d = sticky_q & ~bus.clear_flags;
    if (bus.load) begin
      q_d = load_clamped_c;
    end else if (step_c) begin
      if (oor_c) begin
        q_d = '0;
      end else if (bus.direction) begin
        if (q_q == MAX_Q) begin
          q_d     = SATURATE ? MAX_Q : '0;
          carry_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          q_d      = SATURATE ? '0 : MAX_Q;
          borrow_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
    if (carry_d || borrow_d) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      q_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.q            = q_q;
  assign bus.carry        = carry_q;
  assign bus.borrow       = borrow_q;
  assign bus.event_sticky = sticky_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed vector bench for updown_counter_param across wrap, saturate and non-power-of-two configurations.
module tb_updown_counter_param;

  typedef struct {
    int         sel;
    logic       rst;
    logic       en;
    logic       dir;
    logic       ld;
    logic [3:0] ldv;
    logic       clr;
    logic [3:0] eq;
    logic       ec;
    logic       eb;
    logic       es;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       en, dir, ld, clr;
  logic [3:0] ldv;

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  // sel 0: 3-bit full range wrap, sel 1: 0..9 wrap, sel 2: 0..9 saturate
  updown_counter_param_if #(.WIDTH(3)) if_a ();
  updown_counter_param_if #(.WIDTH(4)) if_b ();
  updown_counter_param_if #(.WIDTH(4)) if_c ();

  updown_counter_param #(.WIDTH(3), .MAX_VAL(7), .SATURATE(1'b0), .PRESCALE(1))
    dut_a (.clock(clock), .reset(reset), .bus(if_a));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(1))
    dut_b (.clock(clock), .reset(reset), .bus(if_b));
  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .PRESCALE(1))
    dut_c (.clock(clock), .reset(reset), .bus(if_c));

  assign if_a.enable = en;  assign if_a.direction = dir; assign if_a.load = ld;
  assign if_a.load_value = ldv[2:0]; assign if_a.clear_flags = clr;
  assign if_b.enable = en;  assign if_b.direction = dir; assign if_b.load = ld;
  assign if_b.load_value = ldv; assign if_b.clear_flags = clr;
  assign if_c.enable = en;  assign if_c.direction = dir; assign if_c.load = ld;
  assign if_c.load_value = ldv; assign if_c.clear_flags = clr;

`ifdef COUNTER_PRESCALE_EN
  updown_counter_param_if #(.WIDTH(4)) if_p ();
  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .PRESCALE(4))
    dut_p (.clock(clock), .reset(reset), .bus(if_p));
  assign if_p.enable = en;  assign if_p.direction = dir; assign if_p.load = ld;
  assign if_p.load_value = ldv; assign if_p.clear_flags = clr;
`endif

  vec_t tbl[$];

  function automatic vec_t mk(int sel, logic rst, logic e, logic d, logic l, logic [3:0] lv,
                              logic c, logic [3:0] q, logic ca, logic bo, logic st);
    vec_t v;
    v.sel = sel; v.rst = rst; v.en = e; v.dir = d; v.ld = l; v.ldv = lv; v.clr = c;
    v.eq = q; v.ec = ca; v.eb = bo; v.es = st;
    return v;
  endfunction

  function automatic logic [6:0] observe(int sel);
    case (sel)
      0:       return {1'b0, if_a.q, if_a.carry, if_a.borrow, if_a.event_sticky};
      1:       return {if_b.q, if_b.carry, if_b.borrow, if_b.event_sticky};
`ifdef COUNTER_PRESCALE_EN
      3:       return {if_p.q, if_p.carry, if_p.borrow, if_p.event_sticky};
`endif
      default: return {if_c.q, if_c.carry, if_c.borrow, if_c.event_sticky};
    endcase
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [6:0] act, exp;
    reset = v.rst; en = v.en; dir = v.dir; ld = v.ld; ldv = v.ldv; clr = v.clr;
    @(posedge clock);
    #1;
    act = observe(v.sel);
    exp = {v.eq, v.ec, v.eb, v.es};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got q=%0d c=%b b=%b s=%b, want q=%0d c=%b b=%b s=%b",
               name, v.sel, act[6:3], act[2], act[1], act[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; en = 1'b0; dir = 1'b0; ld = 1'b0; ldv = '0; clr = 1'b0;

    // 3-bit wrap: count 1..7, 0, 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 7; i++) tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 4'(i), 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1));
    // 0..9 wrap: borrow from 0, load clamp, carry at 9, load at 0 without borrow
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 9, 0, 1, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 8, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 7, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 6, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 15, 0, 9, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // 0..9 saturate: hold at limits with repeated pulses, set-wins-over-clear
    tbl.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(2, 1, 0, 0, 1, 12, 0, 9, 0, 0, 0));
    tbl.push_back(mk(2, 1, 1, 1, 0, 0, 0, 9, 1, 0, 1));
    tbl.push_back(mk(2, 1, 1, 1, 0, 0, 0, 9, 1, 0, 1));
    tbl.push_back(mk(2, 1, 0, 1, 0, 0, 0, 9, 0, 0, 1));
    tbl.push_back(mk(2, 1, 1, 1, 0, 0, 1, 9, 1, 0, 1));
    tbl.push_back(mk(2, 1, 0, 1, 0, 0, 1, 9, 0, 0, 0));
    tbl.push_back(mk(2, 1, 1, 0, 0, 0, 0, 8, 0, 0, 0));
    // Load beats enable; reset beats load mid-count
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 5, 0, 5, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 6, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 9, 0, 9, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 6, 0, 6, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Direction toggling every cycle from 5 steps exactly once per edge
    apply(mk(1, 1, 0, 0, 1, 5, 0, 5, 0, 0, 0), "dir_load");
    for (int i = 0; i < 6; i++) begin
      logic d;
      d = (i % 2 == 0);
      apply(mk(1, 1, 1, d, 0, 0, 0, d ? 4'd6 : 4'd5, 0, 0, 0), $sformatf("dir_toggle%0d", i));
    end

`ifdef COUNTER_PRESCALE_EN
    // Prescale by 4: steps on every 4th enabled cycle; a 2-cycle enable gap delays by 2
    apply(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "presc_reset");
    for (int e = 1; e <= 8; e++)
      apply(mk(3, 1, 1, 1, 0, 0, 0, 4'(e / 4), 0, 0, 0), $sformatf("presc_run%0d", e));
    apply(mk(3, 1, 1, 1, 0, 0, 0, 2, 0, 0, 0), "presc_e9");
    apply(mk(3, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0), "presc_gap1");
    apply(mk(3, 1, 0, 1, 0, 0, 0, 2, 0, 0, 0), "presc_gap2");
    apply(mk(3, 1, 1, 1, 0, 0, 0, 2, 0, 0, 0), "presc_e12");
    apply(mk(3, 1, 1, 1, 0, 0, 0, 2, 0, 0, 0), "presc_e13");
    apply(mk(3, 1, 1, 1, 0, 0, 0, 3, 0, 0, 0), "presc_e14");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised up/down counter that generalises the team's fixed 3-bit up/down counter. Adds:
- configurable width and modulus;
- wrap or saturate mode;
- count enable and parallel load;
- registered carry/borrow pulses and a sticky event flag.

Used as a general event/position counter in datapath and control blocks. It can also be chained through carry/borrow to build wider counters.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MAX_VAL, 2**WIDTH-1, top count value; the count range is 0..MAX_VAL (must be <= 2**WIDTH-1)
SATURATE, 0, 0 = wrap at the range limits; 1 = hold at the range limits
PRESCALE, 4, enable divider ratio (>=1); used only with COUNTER_PRESCALE_EN

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
enable  input  1  count enable, sampled every clock
direction  input  1  1 = count up, 0 = count down
load  input  1  parallel load strobe
load_value  input  WIDTH  value loaded when load=1
clear_flags  input  1  clears the sticky flag
q  output  WIDTH  registered count
carry  output  1  one-cycle pulse after an up-step taken at MAX_VAL
borrow  output  1  one-cycle pulse after a down-step taken at 0
event_sticky  output  1  set by any carry/borrow event; held until cleared

Behaviour:
- Interface: reset is synchronous and active-low; clock is the clock. All state updates on the rising edge of clock; all outputs are registered.
- Reset (reset==0 at an edge): q=0, carry=0, borrow=0, event_sticky=0, prescaler=0. Reset overrides every other input.
- Priority per edge: reset > load > counting step > hold.
- Load (load==1):
  - q <= load_value, clamped to MAX_VAL if load_value > MAX_VAL;
  - no step is taken, even if enable==1;
  - carry and borrow are 0 that cycle;
  - load clears the prescaler.
- Step condition: enable==1 and load==0 (plus the prescaler tick when the optional feature is compiled in).
- Up step:
  - q < MAX_VAL: q <= q+1.
  - q == MAX_VAL: q <= 0 (SATURATE=0) or q <= MAX_VAL (SATURATE=1). In both modes carry=1 on the next cycle.
- Down step:
  - q > 0: q <= q-1.
  - q == 0: q <= MAX_VAL (SATURATE=0) or q <= 0 (SATURATE=1). In both modes borrow=1 on the next cycle.
- carry and borrow:
  - each is high for exactly one cycle per limit event;
  - the two are never high together;
  - both are 0 on any edge without a step at a limit.
  - Latency: the pulse appears in the same cycle that q shows the post-step value.
- event_sticky:
  - set on any edge that produces carry or borrow;
  - cleared by clear_flags==1;
  - set wins over clear on the same edge.
- direction may change on any cycle; the value sampled at the edge governs that edge. No glitch or extra step results.
- If q is out of range (only possible with a non-power-of-two MAX_VAL and a corrupt state), the next step forces q <= 0 and no pulse.
- Arithmetic is modulo 2**WIDTH internally; the range checks above are applied before the update, so no unintended overflow occurs.

Optional Feature:
Macro COUNTER_PRESCALE_EN.
- Defined:
  - an internal prescaler counts enabled cycles 0..PRESCALE-1;
  - a step is taken only on the enabled cycle where the prescaler is PRESCALE-1, after which the prescaler returns to 0;
  - the prescaler holds while enable==0;
  - reset and load clear the prescaler;
  - PRESCALE=1 behaves as not defined.
- Not defined: no prescaler logic; every enabled, non-load cycle is a step.

Test Plan:
1. WIDTH=3, MAX_VAL=7, SATURATE=0: reset low 1 cycle, then enable=1, direction=1 for 9 cycles -> q sequence 1..7, 0, 1; carry high only in the cycle q shows 0; event_sticky=1 afterwards.
2. WIDTH=4, MAX_VAL=9, SATURATE=0, direction=0 from q=0 -> q=9, borrow pulse 1 cycle; 3 more steps -> 8, 7, 6.
3. WIDTH=4, MAX_VAL=9, SATURATE=1: load_value=12 -> q=9 (clamped); step up -> q stays 9 and carry pulses; each further up-step pulses carry again.
4. load=1 with enable=1 and load_value=5 -> q=5, no step; reset=0 asserted mid-count at q=6 with load=1 -> q=0, all flags 0.
5. Sticky flag: clear_flags=1 on the same edge as a carry event -> event_sticky stays 1; on the next edge with clear_flags=1 and no event -> event_sticky=0.
6. COUNTER_PRESCALE_EN defined, PRESCALE=4, enable=1 continuously -> q increments every 4th cycle; enable dropped for 2 cycles mid-period -> the step is delayed by exactly 2 cycles.
